// File: rtl/riscv_run_ctrl_pkg.sv
// Shared definitions for the RISC-V run controller: instruction encodings
// that end a run, FSM state encodings and halt_cause codes.
package riscv_tb_pkg;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] HC_TIMEOUT = 2'd0;
    localparam logic [1:0] HC_ECALL   = 2'd1;
    localparam logic [1:0] HC_EBREAK  = 2'd2;
    localparam logic [1:0] HC_LOOP    = 2'd3;

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// Retire trace from the core under control.
//   retire : one instruction retired this cycle
//   pc     : PC of the retiring instruction
//   instr  : encoding of the retiring instruction
//   a0     : current x10 value
// master = core side (drives), slave = run controller (observes).
interface riscv_run_ctrl_if #(
    parameter int XLEN = 32
) ();

    logic            retire;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] a0;

    modport master (output retire, pc, instr, a0);
    modport slave  (input  retire, pc, instr, a0);

endinterface

// File: rtl/riscv_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear (same effect as reset)
//   en         : count enable
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for a RISC-V core under test: holds the core in reset for
// RESET_CYCLES after start, lets it run, and stops on ECALL, EBREAK, a tight
// self-loop or a cycle budget, reporting cause, pass flag and counters.
//   clk, reset    : clock, synchronous active-high reset
//   start         : request a run (accepted in IDLE or DONE)
//   trace         : retire trace from the core (slave modport)
//   core_reset    : reset to the core under control
//   running, done : RUN / DONE state flags
//   pass          : run ended by ECALL with a0 == 0
//   halt_cause    : 0 timeout, 1 ECALL, 2 EBREAK, 3 self-loop
//   cycle_count   : RUN cycles elapsed
//   instret_count : instructions retired in RUN
//
// state   | meaning
// IDLE    | after reset, core held in reset, waiting for start
// HOLD    | core held in reset for RESET_CYCLES, counters cleared on entry
// RUN     | core released, counting cycles/retires, watching for halt
// DONE    | results frozen, core released, waiting for start
module riscv_run_ctrl
    import riscv_tb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int LOOP_LIMIT     = 8,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    riscv_run_ctrl_if.slave    trace,
    output logic               core_reset,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instret_count
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_LIMIT + 1);

    state_t          state, state_next;
    logic [HW-1:0]   hold_cnt;
    logic [XLEN-1:0] last_pc;
    logic [LW-1:0]   run_len;

    logic            launch;
    logic            in_run, ret_run;
    logic            is_ecall, is_ebreak, loop_hit, timeout_hit, halt;
    logic [1:0]      cause_next;

    assign in_run    = (state == ST_RUN);
    assign ret_run   = in_run && trace.retire;
    assign is_ecall  = ret_run && (trace.instr == INSTR_ECALL);
    assign is_ebreak = ret_run && (trace.instr == INSTR_EBREAK);

    // run_len holds the length of the current same-PC streak; this retire
    // would make it LOOP_LIMIT.
    assign loop_hit  = ret_run && (trace.pc == last_pc) &&
                       (run_len == LW'(LOOP_LIMIT - 1));

    // The halting cycle is itself counted, so the budget is hit when the
    // count is one short of TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_run &&
                         (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    assign halt = is_ecall || is_ebreak || loop_hit || timeout_hit;

    always_comb begin
        cause_next = HC_TIMEOUT;
        if (is_ecall)       cause_next = HC_ECALL;
        else if (is_ebreak) cause_next = HC_EBREAK;
        else if (loop_hit)  cause_next = HC_LOOP;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        core_reset = 1'b1;
        running    = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_HOLD;
                    launch     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) state_next = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                running    = 1'b1;
                if (halt) state_next = ST_DONE;
            end
            ST_DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
                if (start) begin
                    state_next = ST_HOLD;
                    launch     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            last_pc    <= '0;
            run_len    <= '0;
            pass       <= 1'b0;
            halt_cause <= HC_TIMEOUT;
        end else if (launch) begin
            hold_cnt   <= HW'(RESET_CYCLES - 1);
            last_pc    <= '0;
            run_len    <= '0;
            pass       <= 1'b0;
            halt_cause <= HC_TIMEOUT;
        end else begin
            if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            // run_len == 0 means no retire seen yet this run, so the first
            // retire always starts a fresh streak of length 1.
            if (ret_run) begin
                last_pc <= trace.pc;
                if ((run_len != '0) && (trace.pc == last_pc)) run_len <= run_len + 1'b1;
                else                                           run_len <= LW'(1);
            end
            if (in_run && halt) begin
                halt_cause <= cause_next;
                pass       <= is_ecall && (trace.a0 == '0);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    (in_run),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    (ret_run),
        .count (instret_count)
    );

endmodule

// File: tb/tb_riscv_run_ctrl.sv
module tb_riscv_run_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL0   = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        core_reset, running, done, pass;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, instret_count;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_run_ctrl_if #(.XLEN(32)) trace ();

    riscv_run_ctrl #(
        .XLEN(32), .RESET_CYCLES(4), .TIMEOUT_CYCLES(50), .LOOP_LIMIT(8), .CNT_W(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .trace         (trace),
        .core_reset    (core_reset),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .halt_cause    (halt_cause),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, ret;
        logic [31:0] pc, instr, a0;
        logic        e_cr, e_run, e_done, e_pass;
        logic [1:0]  e_cause;
        logic [31:0] e_cyc, e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, st, ret,
                                input logic [31:0] pc, instr, a0,
                                input logic cr, rn, dn, ps,
                                input logic [1:0] cs,
                                input logic [31:0] cy, it);
        vec_t v;
        v.rst = rst; v.st = st; v.ret = ret;
        v.pc = pc; v.instr = instr; v.a0 = a0;
        v.e_cr = cr; v.e_run = rn; v.e_done = dn; v.e_pass = ps;
        v.e_cause = cs; v.e_cyc = cy; v.e_inst = it;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic cr, rn, dn, ps,
                           input logic [1:0] cs, input logic [31:0] cy, it);
        check({tag, ".core_reset"}, 32'(core_reset), 32'(cr));
        check({tag, ".running"},    32'(running),    32'(rn));
        check({tag, ".done"},       32'(done),       32'(dn));
        check({tag, ".pass"},       32'(pass),       32'(ps));
        check({tag, ".halt_cause"}, 32'(halt_cause), 32'(cs));
        check({tag, ".cycle_count"},   cycle_count,   cy);
        check({tag, ".instret_count"}, instret_count, it);
    endtask

    // Inputs change #1 after an edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ret, input logic [31:0] pc, instr, a0);
        trace.retire = ret;
        trace.pc     = pc;
        trace.instr  = instr;
        trace.a0     = a0;
    endtask

    // Start pulse, four HOLD cycles, then the core should be released.
    task automatic do_start(input string tag);
        drive(1'b0, 32'h0, NOP, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, ".hold_cr"}, 32'(core_reset), 32'd1);
        repeat (3) step();
        check({tag, ".hold_last"}, 32'(running), 32'd0);
        step();
        check({tag, ".released"}, 32'(running), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // reset, start, HOLD (start in HOLD ignored), RUN
        vecs.push_back(mk(1,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(1,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,1,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,1,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,0,0, 0, 0,0));
        // ten retires (one with start held, ignored in RUN), then ECALL a0=0
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, (i == 4), 1, 32'(4*i), NOP, 32'd5,
                              0,1,0,0, 0, 32'(i+1), 32'(i+1)));
        vecs.push_back(mk(0,0,1, 32'h28, ECALL, 0, 0,0,1,1, 1, 11,11));
        // DONE ignores trace activity
        vecs.push_back(mk(0,0,1, 32'h2c, EBREAK, 9, 0,0,1,1, 1, 11,11));
        vecs.push_back(mk(0,0,0, 32'h2c, ECALL,  0, 0,0,1,1, 1, 11,11));
        // restart from DONE clears everything; EBREAK run
        vecs.push_back(mk(0,1,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,0,0, 0, 0,0));
        vecs.push_back(mk(0,0,0, 32'h0, ECALL, 0, 0,1,0,0, 0, 1,0));
        vecs.push_back(mk(0,0,1, 32'h0, NOP,   0, 0,1,0,0, 0, 2,1));
        vecs.push_back(mk(0,0,1, 32'h4, EBREAK,0, 0,0,1,0, 2, 3,2));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            start = vecs[i].st;
            drive(vecs[i].ret, vecs[i].pc, vecs[i].instr, vecs[i].a0);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_cr, vecs[i].e_run, vecs[i].e_done,
                    vecs[i].e_pass, vecs[i].e_cause, vecs[i].e_cyc, vecs[i].e_inst);
        end
        reset = 1'b0;
        start = 1'b0;

        // self-loop: streak at 0x40 broken by 0x44, then 8 retires at 0x44 halt
        do_start("loop");
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h40, JAL0, 32'h0);
            step();
            check($sformatf("loop40_%0d.running", k), 32'(running), 32'd1);
        end
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h44, JAL0, 32'h0);
            step();
            check($sformatf("loop44_%0d.running", k), 32'(running), 32'd1);
        end
        drive(1'b1, 32'h44, JAL0, 32'h0);
        step();
        drive(1'b0, 32'h0, NOP, 32'h0);
        chk_all("loop_halt", 0,0,1,0, 2'd3, 15, 15);

        // timeout after exactly 50 RUN cycles, counters then frozen
        do_start("tmo");
        repeat (49) step();
        check("tmo49.running", 32'(running), 32'd1);
        check("tmo49.cycle_count", cycle_count, 32'd49);
        step();
        chk_all("tmo_halt", 0,0,1,0, 2'd0, 50, 0);
        step();
        check("tmo_frozen.cycle_count", cycle_count, 32'd50);

        // ECALL in the timeout cycle wins
        do_start("tmo_ecall");
        repeat (49) step();
        drive(1'b1, 32'h100, ECALL, 32'h0);
        step();
        drive(1'b0, 32'h0, NOP, 32'h0);
        chk_all("tmo_ecall", 0,0,1,1, 2'd1, 50, 1);

        // reset together with start in DONE: reset wins
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk_all("rst_start", 1,0,0,0, 2'd0, 0, 0);
        step();
        check("rst_start_idle.running", 32'(running), 32'd0);

        // reset mid-RUN
        do_start("midrun");
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(8*k), NOP, 32'h0);
            step();
        end
        check("midrun.instret", instret_count, 32'd3);
        reset = 1'b1;
        drive(1'b1, 32'h20, ECALL, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, NOP, 32'h0);
        chk_all("midrun_rst", 1,0,0,0, 2'd0, 0, 0);
        step();
        chk_all("midrun_idle", 1,0,0,0, 2'd0, 0, 0);

        // ECALL with nonzero a0 fails
        do_start("ecall_fail");
        drive(1'b1, 32'h0, ECALL, 32'h7);
        step();
        drive(1'b0, 32'h0, NOP, 32'h0);
        chk_all("ecall_fail", 0,0,1,0, 2'd1, 1, 1);

        // EBREAK on the loop-limit retire outranks self-loop
        do_start("brk_loop");
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h80, NOP, 32'h0);
            step();
        end
        drive(1'b1, 32'h80, EBREAK, 32'h0);
        step();
        drive(1'b0, 32'h0, NOP, 32'h0);
        chk_all("brk_loop", 0,0,1,0, 2'd2, 8, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning core data/PC width.
REQ-002 SHALL have parameter RESET_CYCLES, default 4, meaning core_reset hold length in cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning RUN cycle budget (0 = timeout disabled).
REQ-004 SHALL have parameter LOOP_LIMIT, default 8, meaning consecutive same-PC retires that count as a halt (>=2).
REQ-005 SHALL have parameter CNT_W, default 32, meaning counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request a run.
REQ-009 SHALL have port retire, input, 1 bit: the core retired one instruction this cycle.
REQ-010 SHALL have port pc, input, XLEN bits: PC of the retiring instruction.
REQ-011 SHALL have port instr, input, 32 bits: encoding of the retiring instruction.
REQ-012 SHALL have port a0, input, XLEN bits: current x10 value, used for pass/fail.
REQ-013 SHALL have port core_reset, output, 1 bit: drives the reset input of the core under control.
REQ-014 SHALL have port running, output, 1 bit: high in RUN.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port pass, output, 1 bit: run ended by ECALL with a0==0.
REQ-017 SHALL have port halt_cause, output, 2 bits: 0 timeout, 1 ECALL, 2 EBREAK, 3 self-loop.
REQ-018 SHALL have port cycle_count, output, CNT_W bits: RUN cycles elapsed.
REQ-019 SHALL have port instret_count, output, CNT_W bits: instructions retired in RUN.

Function
REQ-020 SHALL implement FSM IDLE -> HOLD -> RUN -> DONE; start in IDLE or DONE -> HOLD; start in HOLD/RUN is ignored.
REQ-021 SHALL, on entry to HOLD, clear counters, pass, halt_cause and the loop tracker.
REQ-022 SHALL keep core_reset=1 in IDLE and HOLD, 0 in RUN and DONE; HOLD SHALL last exactly RESET_CYCLES cycles.
REQ-023 SHALL increment cycle_count by 1 every RUN cycle, including the halting cycle; saturate at all-ones.
REQ-024 SHALL increment instret_count on each RUN cycle with retire=1; saturate; freeze both counters outside RUN.
REQ-025 SHALL detect ECALL (0x00000073) and EBREAK (0x00100073) only when retire=1 in RUN; DONE is entered the next cycle.
REQ-026 SHALL track consecutive retires with pc equal to the previously retired pc; a differing pc resets the run length to 1; the LOOP_LIMIT-th equal-pc retire halts with cause 3.
REQ-027 SHALL halt with cause 0 when TIMEOUT_CYCLES!=0 and cycle_count reaches TIMEOUT_CYCLES in RUN without another halt in that cycle.
REQ-028 SHALL prioritise simultaneous halt causes ECALL > EBREAK > self-loop > timeout.
REQ-029 SHALL set pass=1 only for cause 1 with a0==0 sampled in the halting cycle; otherwise pass=0.
REQ-030 SHALL hold done, pass, halt_cause and counters stable in DONE until start or reset.
REQ-031 SHALL ignore retire, pc, instr and a0 outside RUN.

Reset
REQ-032 SHALL, on reset=1 at a clock edge in any state (including mid-run), enter IDLE with core_reset=1, running=0, done=0, pass=0, halt_cause=0, cycle_count=0, instret_count=0.
REQ-033 SHALL give reset priority over start in the same cycle.

Structure
REQ-034 SHALL place the ECALL/EBREAK encodings, FSM state encodings and halt_cause codes in shared package riscv_tb_pkg.
REQ-035 SHALL use one sub-module, sat_counter (parametrised width, enable, sync clear, saturating), instantiated for cycle_count and instret_count.

Verification
REQ-036 SHALL cover: reset 2 cycles, start 1 cycle, RESET_CYCLES=4 -> core_reset high exactly 4 cycles after start, then running=1.
REQ-037 SHALL cover: 10 retires, then ECALL retire with a0=0 -> next cycle done=1, pass=1, halt_cause=1, instret_count=11.
REQ-038 SHALL cover: EBREAK retire with a0=0 -> done=1, pass=0, halt_cause=2.
REQ-039 SHALL cover: LOOP_LIMIT=8, jal x0,0 (0x0000006F) retired repeatedly at pc 0x40 -> halt on 8th retire, halt_cause=3.
REQ-040 SHALL cover: TIMEOUT_CYCLES=50, no retire -> done=1, cycle_count=50, halt_cause=0; ECALL in the same cycle as timeout -> halt_cause=1.
REQ-041 SHALL cover: reset asserted mid-RUN -> next cycle IDLE, all outputs at reset values; start in DONE restarts with counters cleared.
